hole_pocket_detector: RTL and testbench
=======================================

Name: hole_pocket_detector

Overview:
- Consumes the registered drawingRequest outputs of all table hole objects and all ball objects; decides once per frame which balls have dropped into a pocket.
- Counts per-ball pixel overlap with any hole during the visible frame. At startOfFrame it scans the balls one per cycle and emits pocket events to the game-logic controller.
- Sits directly downstream of the hole and ball drawing objects, in parallel with the video object mux.

Parameters:
- NUM_BALLS, 16, number of ball drawingRequest lines; index 0 is the cue ball.
- NUM_HOLES, 6, number of hole drawingRequest lines.
- MIN_OVERLAP, 40, overlap pixels per frame at or above which a ball is pocketed.
- CNT_W, 8, per-ball overlap counter width; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- resetN  input  1  asynchronous active-low reset.
- startOfFrame  input  1  single-cycle pulse at frame start, during vertical blanking.
- newGame  input  1  synchronous clear of all pocket state.
- holesDrawingRequest  input  NUM_HOLES  per-hole drawingRequest, pixel-aligned with the ball requests.
- ballsDrawingRequest  input  NUM_BALLS  per-ball drawingRequest.
- pocketPulse  output  1  one-cycle pulse: a non-cue ball was pocketed.
- pocketBallIdx  output  4  ball index for the current pocketPulse or cueScratch.
- pocketHoleIdx  output  3  hole index for the current pocketPulse or cueScratch.
- cueScratch  output  1  one-cycle pulse: the cue ball was pocketed.
- pocketedMask  output  NUM_BALLS  sticky bit per pocketed ball; bit 0 is always 0.
- pocketedCount  output  4  number of bits set in pocketedMask.
- scanBusy  output  1  high while in SCAN.

Behaviour:
- Reset (resetN=0, asynchronous):
  - State is ACCUM.
  - All counters, holeIdx registers, and the scan index are 0.
  - Every output is 0.
- State ACCUM:
  - Each cycle, for each ball i: if ballsDrawingRequest[i] and any holesDrawingRequest bit are set, the counter for ball i increments, saturating.
  - On the first such pixel of the frame (counter==0), holeIdx[i] latches the lowest-index asserted hole bit.
  - Pixels in the cycle where startOfFrame=1 are not counted.
  - startOfFrame=1 moves the block to SCAN with scan index 0.
- State SCAN (entered at cycle T+1 after startOfFrame at T):
  - Ball i is evaluated in cycle T+1+i; its registered result is visible in cycle T+2+i.
  - Pocketing condition: counter[i] >= MIN_OVERLAP and pocketedMask[i]=0.
  - If the condition holds and i>0:
    - pocketPulse=1 for one cycle.
    - pocketBallIdx=i, pocketHoleIdx=holeIdx[i].
    - pocketedMask[i] is set and pocketedCount increments, in the same cycle as the pulse.
  - If the condition holds and i=0:
    - cueScratch=1 for one cycle.
    - pocketBallIdx=0, pocketHoleIdx=holeIdx[0].
    - No mask or count change; the cue ball can scratch again in later frames.
  - Pulses never assert while in ACCUM, except the final scan result, which appears in the first ACCUM cycle.
  - pocketBallIdx and pocketHoleIdx hold their last value when no pulse is asserted.
  - After ball NUM_BALLS-1, all counters and holeIdx registers clear and the state returns to ACCUM (cycle T+1+NUM_BALLS).
  - Pixel inputs are ignored during SCAN.
  - startOfFrame during SCAN is ignored.
  - scanBusy=1 throughout SCAN.
- newGame=1 (highest priority, any state):
  - Next cycle: state ACCUM; counters, holeIdx, pocketedMask, and pocketedCount are all 0.
  - Pulses are 0.
  - Any in-progress scan is aborted with no further pulses.
  - newGame together with startOfFrame gives ACCUM, not SCAN.
- Reset mid-scan: immediate return to the reset state, with no pulse emitted.
- Width rules:
  - pocketedCount is 4 bits; the maximum reachable value is NUM_BALLS-1=15, so it cannot wrap.
  - Counter saturation at 255 means a ball can never appear to un-pocket through counter wrap.

Test Plan:
- Reset, then ball 5 and hole 2 both asserted for 60 cycles, then startOfFrame at T:
  - pocketPulse=1 at T+7 with pocketBallIdx=5 and pocketHoleIdx=2.
  - pocketedMask=0x0020 and pocketedCount=1 at T+7.
  - scanBusy high from T+1 to T+16.
- Ball 3 overlaps hole 0 for exactly 39 cycles → no pulse on the scan. The next frame overlaps for 40 cycles → pulse with idx 3.
- Ball 0 overlaps hole 4 for 100 cycles in each of two frames:
  - cueScratch pulses in both scans, with pocketHoleIdx=4.
  - pocketedMask stays 0.
- Ball 7 pocketed in frame 1 and overlapping again in frame 2 → no second pulse; pocketedCount stays 1.
- Balls 1 and 9 both qualify in the same frame → pulses at T+3 (idx 1) and T+11 (idx 9); pocketedCount=2.
- newGame asserted at T+4 during a scan in which ball 9 qualifies:
  - No pulse for ball 9.
  - pocketedMask=0 and pocketedCount=0.
  - State ACCUM.
  - Overlap with 300 cycles in a frame saturates the counter at 255 and still pockets.

Source files
------------

// File: rtl/hole_pocket_detector.sv
// Per-frame pocket detection: accumulates ball/hole pixel overlap while the frame
// is drawn, then walks the balls one per cycle at startOfFrame and reports pockets.
module hole_pocket_detector #(
  parameter int NUM_BALLS   = 16,
  parameter int NUM_HOLES   = 6,
  parameter int MIN_OVERLAP = 40,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 newGame,
  input  logic [NUM_HOLES-1:0] holesDrawingRequest,
  input  logic [NUM_BALLS-1:0] ballsDrawingRequest,
  output logic                 pocketPulse,
  output logic [3:0]           pocketBallIdx,
  output logic [2:0]           pocketHoleIdx,
  output logic                 cueScratch,
  output logic [NUM_BALLS-1:0] pocketedMask,
  output logic [3:0]           pocketedCount,
  output logic                 scanBusy
);

  localparam int SCAN_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(MIN_OVERLAP);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [SCAN_W-1:0] LAST_BALL = SCAN_W'(NUM_BALLS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    SCAN  = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [SCAN_W-1:0] scan_idx;
  logic [CNT_W-1:0]  overlap_cnt [NUM_BALLS];
  logic [2:0]        hole_idx    [NUM_BALLS];
  logic              any_hole;
  logic [2:0]        first_hole;
  logic              scan_hit;
  logic              scan_last;
  logic              counting;

  assign any_hole = |holesDrawingRequest;
  assign scanBusy = (state == SCAN);
  assign counting = (state == ACCUM) && !startOfFrame && !newGame && any_hole;

  // Lowest-index hole wins when several holes share the pixel.
  always_comb begin
    first_hole = '0;
    for (int h = NUM_HOLES - 1; h >= 0; h--) begin
      if (holesDrawingRequest[h]) begin
        first_hole = 3'(h);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    scan_hit   = 1'b0;
    scan_last  = 1'b0;
    if (newGame) begin
      next_state = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (startOfFrame) begin
            next_state = SCAN;
          end
        end
        SCAN: begin
          scan_hit  = (overlap_cnt[scan_idx] >= THRESH) && !pocketedMask[scan_idx];
          scan_last = (scan_idx == LAST_BALL);
          if (scan_last) begin
            next_state = ACCUM;
          end
        end
      endcase
    end
  end

  // Saturating counters cannot wrap, so a pocketed ball never looks un-pocketed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        overlap_cnt[i] <= '0;
        hole_idx[i]    <= '0;
      end
    end else if (newGame || scan_last) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        overlap_cnt[i] <= '0;
        hole_idx[i]    <= '0;
      end
    end else if (counting) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (ballsDrawingRequest[i]) begin
          if (overlap_cnt[i] == '0) begin
            hole_idx[i] <= first_hole;
          end
          if (overlap_cnt[i] != CNT_MAX) begin
            overlap_cnt[i] <= overlap_cnt[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // The cue ball only scratches; it is never recorded as pocketed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scan_idx      <= '0;
      pocketPulse   <= 1'b0;
      cueScratch    <= 1'b0;
      pocketBallIdx <= '0;
      pocketHoleIdx <= '0;
      pocketedMask  <= '0;
      pocketedCount <= '0;
    end else begin
      pocketPulse <= 1'b0;
      cueScratch  <= 1'b0;
      if (newGame) begin
        scan_idx      <= '0;
        pocketedMask  <= '0;
        pocketedCount <= '0;
      end else if (state == SCAN) begin
        scan_idx <= scan_last ? '0 : scan_idx + SCAN_ONE;
        if (scan_hit) begin
          pocketBallIdx <= 4'(scan_idx);
          pocketHoleIdx <= hole_idx[scan_idx];
          if (scan_idx == '0) begin
            cueScratch <= 1'b1;
          end else begin
            pocketPulse            <= 1'b1;
            pocketedMask[scan_idx] <= 1'b1;
            pocketedCount          <= pocketedCount + 4'd1;
          end
        end
      end else if (startOfFrame) begin
        scan_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hole_pocket_detector.sv
// Bench for hole_pocket_detector: directed frames with literal expectations plus
// randomized frames checked every cycle against a frame-level event model.
module tb_hole_pocket_detector;

  localparam int NB  = 16;
  localparam int NH  = 6;
  localparam int MIN = 40;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic          newGame = 1'b0;
  logic [NH-1:0] holesDrawingRequest = '0;
  logic [NB-1:0] ballsDrawingRequest = '0;
  logic          pocketPulse;
  logic [3:0]    pocketBallIdx;
  logic [2:0]    pocketHoleIdx;
  logic          cueScratch;
  logic [NB-1:0] pocketedMask;
  logic [3:0]    pocketedCount;
  logic          scanBusy;

  int total = 0;
  int bad = 0;
  int pulse_total = 0;
  int cue_total = 0;
  bit check_en = 1'b0;

  hole_pocket_detector #(
    .NUM_BALLS(NB), .NUM_HOLES(NH), .MIN_OVERLAP(MIN), .CNT_W(8)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .newGame(newGame),
    .holesDrawingRequest(holesDrawingRequest),
    .ballsDrawingRequest(ballsDrawingRequest),
    .pocketPulse(pocketPulse),
    .pocketBallIdx(pocketBallIdx),
    .pocketHoleIdx(pocketHoleIdx),
    .cueScratch(cueScratch),
    .pocketedMask(pocketedMask),
    .pocketedCount(pocketedCount),
    .scanBusy(scanBusy)
  );

  always #5 clk = ~clk;

  // Frame-level model: overlap totals per ball, and at frame start a list of
  // scheduled pocket events keyed by the clock edge at which they must appear.
  typedef struct {
    int at_edge;
    int ball;
    int hole;
  } ev_t;

  ev_t           evq[$];
  int            ov[NB];
  int            first_hl[NB];
  int            edge_n = 0;
  int            scan_start = 0;
  bit            scanning = 1'b0;
  logic          m_pulse = 1'b0;
  logic          m_cue = 1'b0;
  logic          m_busy = 1'b0;
  logic [3:0]    m_bidx = '0;
  logic [2:0]    m_hidx = '0;
  logic [NB-1:0] m_mask = '0;

  task automatic model_clear_frame();
    for (int i = 0; i < NB; i++) begin
      ov[i] = 0;
      first_hl[i] = 0;
    end
  endtask

  task automatic model_step();
    ev_t ev;
    int lo;
    if (!resetN) begin
      model_clear_frame();
      evq.delete();
      scanning = 1'b0;
      m_pulse = 1'b0;
      m_cue = 1'b0;
      m_busy = 1'b0;
      m_bidx = '0;
      m_hidx = '0;
      m_mask = '0;
      return;
    end
    edge_n++;
    m_pulse = 1'b0;
    m_cue = 1'b0;
    if (newGame) begin
      model_clear_frame();
      evq.delete();
      m_mask = '0;
      scanning = 1'b0;
    end else if (scanning) begin
      if (evq.size() > 0 && evq[0].at_edge == edge_n) begin
        ev = evq.pop_front();
        m_bidx = 4'(ev.ball);
        m_hidx = 3'(ev.hole);
        if (ev.ball == 0) begin
          m_cue = 1'b1;
        end else begin
          m_pulse = 1'b1;
          m_mask[ev.ball] = 1'b1;
        end
      end
      if (edge_n == scan_start + NB) scanning = 1'b0;
    end else if (startOfFrame) begin
      scanning = 1'b1;
      scan_start = edge_n;
      for (int i = 0; i < NB; i++) begin
        if (ov[i] >= MIN && !m_mask[i]) evq.push_back('{scan_start + 1 + i, i, first_hl[i]});
      end
      model_clear_frame();
    end else if (holesDrawingRequest != '0) begin
      lo = 0;
      for (int h = NH - 1; h >= 0; h--) if (holesDrawingRequest[h]) lo = h;
      for (int i = 0; i < NB; i++) begin
        if (ballsDrawingRequest[i]) begin
          if (ov[i] == 0) first_hl[i] = lo;
          ov[i]++;
        end
      end
    end
    m_busy = scanning;
  endtask

  initial forever begin
    @(posedge clk or negedge resetN);
    model_step();
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (pocketPulse === 1'b1) pulse_total++;
    if (cueScratch === 1'b1) cue_total++;
    if (check_en) begin
      check_output("m_pulse", 32'(pocketPulse), 32'(m_pulse));
      check_output("m_cue", 32'(cueScratch), 32'(m_cue));
      check_output("m_bidx", 32'(pocketBallIdx), 32'(m_bidx));
      check_output("m_hidx", 32'(pocketHoleIdx), 32'(m_hidx));
      check_output("m_mask", 32'(pocketedMask), 32'(m_mask));
      check_output("m_count", 32'(pocketedCount), 32'($countones(m_mask)));
      check_output("m_busy", 32'(scanBusy), 32'(m_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [NB-1:0] balls, input logic [NH-1:0] holes, input int n);
    ballsDrawingRequest = balls;
    holesDrawingRequest = holes;
    tick(n);
    ballsDrawingRequest = '0;
    holesDrawingRequest = '0;
  endtask

  task automatic frame_start();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
  endtask

  task automatic run_scan();
    frame_start();
    tick(NB + 1);
  endtask

  task automatic new_game();
    newGame = 1'b1;
    tick(1);
    newGame = 1'b0;
  endtask

  initial begin
    int p0;
    int c0;
    logic [NB-1:0] hot;
    logic [NH-1:0] hl;
    int len;

    #12;
    check_output("rst_pulse", 32'(pocketPulse), 0);
    check_output("rst_mask", 32'(pocketedMask), 0);
    check_output("rst_busy", 32'(scanBusy), 0);
    check_output("rst_count", 32'(pocketedCount), 0);
    resetN = 1'b1;
    tick(2);
    check_en = 1'b1;

    // Ball 5 over hole 2 for 60 pixels.
    apply_stimulus(16'h0020, 6'b000100, 60);
    frame_start();
    check_output("t1_busy_T1", 32'(scanBusy), 1);
    tick(6);
    check_output("t1_pulse", 32'(pocketPulse), 1);
    check_output("t1_bidx", 32'(pocketBallIdx), 5);
    check_output("t1_hidx", 32'(pocketHoleIdx), 2);
    check_output("t1_mask", 32'(pocketedMask), 32'h0020);
    check_output("t1_count", 32'(pocketedCount), 1);
    tick(9);
    check_output("t1_busy_T16", 32'(scanBusy), 1);
    tick(1);
    check_output("t1_busy_T17", 32'(scanBusy), 0);
    tick(2);

    // Threshold boundary: 39 misses, 40 hits.
    apply_stimulus(16'h0008, 6'b000001, 39);
    run_scan();
    check_output("b3_39", 32'(pocketedMask[3]), 0);
    apply_stimulus(16'h0008, 6'b000001, 40);
    run_scan();
    check_output("b3_40", 32'(pocketedMask[3]), 1);
    check_output("b3_count", 32'(pocketedCount), 2);

    // Cue ball scratches every frame and is never masked.
    c0 = cue_total;
    for (int f = 0; f < 2; f++) begin
      apply_stimulus(16'h0001, 6'b010000, 100);
      frame_start();
      tick(1);
      check_output("cue_pulse", 32'(cueScratch), 1);
      check_output("cue_bidx", 32'(pocketBallIdx), 0);
      check_output("cue_hidx", 32'(pocketHoleIdx), 4);
      tick(NB);
    end
    check_output("cue_total", 32'(cue_total - c0), 2);
    check_output("cue_mask", 32'(pocketedMask), 32'h0028);

    // Already-pocketed ball is not reported again.
    new_game();
    apply_stimulus(16'h0080, 6'b000010, 50);
    run_scan();
    p0 = pulse_total;
    apply_stimulus(16'h0080, 6'b000010, 50);
    run_scan();
    check_output("b7_repeat", 32'(pulse_total - p0), 0);
    check_output("b7_count", 32'(pocketedCount), 1);

    // Two balls in one frame.
    new_game();
    apply_stimulus(16'h0202, 6'b001000, 45);
    frame_start();
    tick(2);
    check_output("b1_pulse", 32'(pocketPulse), 1);
    check_output("b1_bidx", 32'(pocketBallIdx), 1);
    tick(8);
    check_output("b9_pulse", 32'(pocketPulse), 1);
    check_output("b9_bidx", 32'(pocketBallIdx), 9);
    check_output("b9_hidx", 32'(pocketHoleIdx), 3);
    tick(8);
    check_output("b19_count", 32'(pocketedCount), 2);

    // newGame aborts an in-progress scan.
    new_game();
    apply_stimulus(16'h0200, 6'b100000, 50);
    frame_start();
    tick(3);
    newGame = 1'b1;
    tick(1);
    newGame = 1'b0;
    check_output("ng_mask", 32'(pocketedMask), 0);
    check_output("ng_count", 32'(pocketedCount), 0);
    check_output("ng_busy", 32'(scanBusy), 0);
    p0 = pulse_total;
    tick(12);
    check_output("ng_nopulse", 32'(pulse_total - p0), 0);

    // newGame wins over startOfFrame.
    apply_stimulus(16'h0010, 6'b000001, 50);
    newGame = 1'b1;
    startOfFrame = 1'b1;
    tick(1);
    newGame = 1'b0;
    startOfFrame = 1'b0;
    check_output("ngsof_busy", 32'(scanBusy), 0);
    p0 = pulse_total;
    run_scan();
    check_output("ngsof_nopulse", 32'(pulse_total - p0), 0);

    // Saturating overlap still pockets.
    apply_stimulus(16'h0004, 6'b001000, 300);
    frame_start();
    tick(3);
    check_output("sat_pulse", 32'(pocketPulse), 1);
    check_output("sat_bidx", 32'(pocketBallIdx), 2);
    check_output("sat_hidx", 32'(pocketHoleIdx), 3);
    tick(NB - 2);

    // Asynchronous reset in the middle of a scan.
    apply_stimulus(16'h0040, 6'b000100, 50);
    frame_start();
    tick(3);
    #1 resetN = 1'b0;
    #1;
    check_output("ar_busy", 32'(scanBusy), 0);
    check_output("ar_mask", 32'(pocketedMask), 0);
    check_output("ar_pulse", 32'(pocketPulse), 0);
    check_output("ar_bidx", 32'(pocketBallIdx), 0);
    #1 resetN = 1'b1;
    p0 = pulse_total;
    tick(20);
    check_output("ar_nopulse", 32'(pulse_total - p0), 0);

    // Randomized frames against the model.
    for (int f = 0; f < 14; f++) begin
      hot = NB'($urandom) & NB'($urandom);
      len = $urandom_range(40, 160);
      for (int c = 0; c < len + 22; c++) begin
        ballsDrawingRequest = hot & NB'($urandom);
        hl = NH'(1 << $urandom_range(0, NH - 1));
        if ($urandom_range(0, 3) == 0) hl = hl | NH'($urandom);
        holesDrawingRequest = ($urandom_range(0, 2) != 0) ? hl : '0;
        newGame = ($urandom_range(0, 299) == 0);
        startOfFrame = (c == len) || (c > len && $urandom_range(0, 14) == 0);
        tick(1);
      end
      startOfFrame = 1'b0;
      newGame = 1'b0;
      ballsDrawingRequest = '0;
      holesDrawingRequest = '0;
      if (f % 5 == 4) new_game();
    end
    tick(NB + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
